// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, wait-counter
// width and the address-error rule (alignment trap under DATA_MEM_RESP_ALIGN_TRAP_EN).
package data_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // aw is log2 of the word count; any bit above the word index is out of range.
  function automatic logic addrErr(input logic [31:0] addr, input int unsigned aw);
    logic err;
    err = (addr >> (aw + 2)) != 32'd0;
`ifdef DATA_MEM_RESP_ALIGN_TRAP_EN
    err = err || (addr[1:0] != 2'b00);
`endif
    return err;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port DEPTH x 32 word array: synchronous write, registered read.
module data_mem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iWe,
  input  logic                     iRe,
  input  logic [$clog2(DEPTH)-1:0] iAddr,
  input  logic [31:0]              iWrData,
  output logic [31:0]              oRdData
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would cost a write port
  // per word and contents must survive reset anyway.
  always_ff @(posedge iClk) begin
    if (iWe) mem[iAddr] <= iWrData;
  end

  always_ff @(posedge iClk) begin
    if (iRst)     oRdData <= '0;
    else if (iRe) oRdData <= mem[iAddr];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Memory responder: latches a read/write request, waits WAIT cycles, then
// completes it with a one-cycle oAccessable strobe. Optional DATA_MEM_RESP_ALIGN_TRAP_EN.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oAccessable,
  output logic        oErr
);

  localparam int AW = $clog2(DEPTH);

  state_t             state, nextState;
  logic [CNT_W-1:0]   cnt, nextCnt;
  req_t               held, cur;
  logic               start, enterDone, curErr, zeroRd;
  logic [31:0]        arrRdData;

  // In IDLE the live inputs are the request; afterwards the latched copy is,
  // so a WAIT==0 access can complete on the very edge that samples it.
  always_comb begin
    cur = held;
    if (state == ST_IDLE) begin
      cur.wr   = iWr;
      cur.addr = iAddr;
      cur.data = iWrData;
    end
  end

  assign start  = (state == ST_IDLE) && (iRd || iWr);
  assign curErr = addrErr(cur.addr, AW);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned (which would infer a latch); use blocking '=' here.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nextCnt   = CNT_W'(WAIT);
          nextState = (WAIT == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        nextCnt = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) nextState = ST_DONE;
      end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Array is touched only on the edge entering DONE; reset aborts that edge.
  assign enterDone = !iRst && (nextState == ST_DONE) && (state != ST_DONE);

  data_mem_array #(.DEPTH(DEPTH)) u_array (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWe     (enterDone && cur.wr && !curErr),
    .iRe     (enterDone && !cur.wr && !curErr),
    .iAddr   (cur.addr[AW+1:2]),
    .iWrData (cur.data),
    .oRdData (arrRdData)
  );

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      oAccessable <= 1'b0;
      oErr        <= 1'b0;
      zeroRd      <= 1'b0;
    end else begin
      state       <= nextState;
      cnt         <= nextCnt;
      oAccessable <= enterDone;
      oErr        <= enterDone && curErr;
      if (enterDone && !cur.wr) zeroRd <= curErr;
    end
  end

  // Request payload is only consumed after a start, so it needs no reset.
  always_ff @(posedge iClk) begin
    if (start) held <= cur;
  end

  // A failed read reports zero until the next read completes.
  assign oRdData = zeroRd ? 32'd0 : arrRdData;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed table, reset-abort and
// WAIT=0 held-request sequences, then random accesses against a word-array model.
module tb_data_mem_resp;

`ifdef DATA_MEM_RESP_ALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, wr, acc, err;
  logic [31:0] addr, wdata, rdata;
  logic        rd0, wr0, acc0, err0;
  logic [31:0] addr0, wdata0, rdata0;

  data_mem_resp #(.DEPTH(256), .WAIT(2)) dut (
    .iClk(clk), .iRst(rst), .iRd(rd), .iWr(wr), .iAddr(addr), .iWrData(wdata),
    .oRdData(rdata), .oAccessable(acc), .oErr(err)
  );

  data_mem_resp #(.DEPTH(256), .WAIT(0)) dut0 (
    .iClk(clk), .iRst(rst), .iRd(rd0), .iWr(wr0), .iAddr(addr0), .iWrData(wdata0),
    .oRdData(rdata0), .oAccessable(acc0), .oErr(err0)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [256];
  logic [31:0] lastRd;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic modelErr(input logic [31:0] a);
    return (a[31:10] != 22'd0) || (TRAP && (a[1:0] != 2'b00));
  endfunction

  // Reference behaviour: writes update the word unless the address faults; reads
  // return the word (or 0 on a fault) and that value persists until the next read.
  task automatic modelApply(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] expData,
                            output logic expErr);
    expErr = modelErr(a);
    if (w) begin
      if (!expErr) model[a[9:2]] = d;
    end else if (r) begin
      lastRd = expErr ? 32'd0 : model[a[9:2]];
    end
    expData = lastRd;
  endtask

  // Called at a negedge; returns at a negedge one cycle after the strobe.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] gotData,
                        output logic gotErr, output int lat);
    rd = r; wr = w; addr = a; wdata = d;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (!acc) check("err_without_strobe", 32'(err), 32'd0);
    end while (!acc && lat < 40);
    check("strobe_seen", 32'(acc), 32'd1);
    gotData = rdata;
    gotErr  = err;
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); @(negedge clk);
    check("strobe_width", 32'(acc), 32'd0);
    check("err_after_strobe", 32'(err), 32'd0);
  endtask

  task automatic run(input string name, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] got, expData;
    logic gotErr, expErr;
    int lat;
    access(r, w, a, d, got, gotErr, lat);
    modelApply(r, w, a, d, expData, expErr);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_data"}, got, expData);
    check({name, "_err"}, 32'(gotErr), 32'(expErr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, expData, old;
    logic gotErr, expErr;
    int lat;

    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h10000000, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h8,   32'h1,        32'h0,        1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h1,        1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h22,  32'hCAFEF00D, 32'h1,        TRAP};
    vecs[8] = '{1'b1, 1'b0, 32'h20,  32'h0,
                TRAP ? 32'h10000008 : 32'hCAFEF00D, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'h23,  32'h0,
                TRAP ? 32'h0 : 32'hCAFEF00D, TRAP};

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    lastRd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_acc", 32'(acc), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_acc", 32'(acc), 32'd0);
    check("idle_rdata", rdata, 32'd0);

    for (int i = 0; i < 256; i++) run("init", 1'b0, 1'b1, 32'(i * 4), 32'h10000000 + 32'(i));

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, got, gotErr, lat);
      modelApply(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, expData, expErr);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_data", i), got, vecs[i].expData);
      check($sformatf("vec%0d_err", i), 32'(gotErr), 32'(vecs[i].expErr));
    end

    // Reset in the second wait cycle of a write must abort it silently.
    old = model[8];
    wr = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5;
    @(posedge clk); @(negedge clk);
    check("abort_wait1_acc", 32'(acc), 32'd0);
    @(posedge clk); @(negedge clk);
    check("abort_wait2_acc", 32'(acc), 32'd0);
    rst = 1'b1; wr = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    lastRd = '0;
    check("abort_acc", 32'(acc), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("abort_no_strobe", 32'(acc), 32'd0);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, got, gotErr, lat);
    check("abort_old_value", got, old);
    lastRd = old;

    // WAIT=0 with the request held: strobe every second cycle.
    wr0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h11111111;
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("w0_step%0d_acc", s), 32'(acc0), 32'd1);
      check($sformatf("w0_step%0d_err", s), 32'(err0), 32'd0);
      if (s == 2) check("w0_read0_data", rdata0, 32'h11111111);
      if (s == 3) check("w0_read4_data", rdata0, 32'h22222222);
      case (s)
        0: begin addr0 = 32'h4; wdata0 = 32'h22222222; end
        1: begin wr0 = 1'b0; rd0 = 1'b1; addr0 = 32'h0; end
        2: addr0 = 32'h4;
        default: rd0 = 1'b0;
      endcase
      @(posedge clk); @(negedge clk);
      check($sformatf("w0_step%0d_gap", s), 32'(acc0), 32'd0);
    end

    for (int n = 0; n < 300; n++) begin
      logic r, w;
      logic [31:0] a;
      int op, kind;
      op   = $urandom_range(0, 3);
      kind = $urandom_range(0, 7);
      r = (op != 2);
      w = (op >= 2);
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (kind == 0) a[31:10] = 22'($urandom_range(1, 4194303));
      if (kind == 1) a[1:0]   = 2'($urandom_range(1, 3));
      run("rand", r, w, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words in the array (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT, default 2: wait cycles inserted before a response (0..15).
REQ-003 SHALL have port iClk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iRd, input, 1: read request, held by the initiator until oAccessable.
REQ-006 SHALL have port iWr, input, 1: write request, held by the initiator until oAccessable.
REQ-007 SHALL have port iAddr, input, 32: byte address; word index is iAddr[log2(DEPTH)+1:2].
REQ-008 SHALL have port iWrData, input, 32: write data.
REQ-009 SHALL have port oRdData, output, 32: registered read data, valid while oAccessable is high on a read.
REQ-010 SHALL have port oAccessable, output, 1: one-cycle completion strobe.
REQ-011 SHALL have port oErr, output, 1: error flag, valid with oAccessable.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-013 IDLE: when iRd or iWr is high, SHALL latch the request type, address and data, load the counter with WAIT, and go to WAIT (or to DONE if WAIT==0).
REQ-014 WAIT: SHALL decrement the counter each cycle, go to DONE when it reaches 1, and ignore input changes.
REQ-015 The DONE cycle SHALL assert oAccessable for exactly one cycle, then return to IDLE.
REQ-016 Latency from the request edge sampled in IDLE to oAccessable high SHALL be WAIT+1 cycles.
REQ-017 A write SHALL commit to the array on the edge entering DONE and never earlier.
REQ-018 A read SHALL load oRdData on the edge entering DONE; oRdData SHALL hold its value until the next read completes.
REQ-019 When iRd and iWr are both high in IDLE, the access SHALL be treated as a write.
REQ-020 A request still high during the DONE cycle SHALL be ignored; one still high in the following IDLE cycle starts a new transaction.
REQ-021 An out-of-range address (iAddr[31:log2(DEPTH)+2] nonzero) SHALL set oErr with oAccessable, drop a write, and return 0 for a read.
REQ-022 oErr SHALL be low whenever oAccessable is low.

Reset
REQ-023 iRst SHALL force state IDLE, counter 0, oAccessable 0, oErr 0 and oRdData 0x00000000.
REQ-024 Reset during WAIT SHALL abort the access with no array write and no strobe.
REQ-025 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With macro DATA_MEM_RESP_ALIGN_TRAP_EN defined, a nonzero iAddr[1:0] SHALL set oErr in DONE, drop a write, and return 0 for a read.
REQ-027 Without DATA_MEM_RESP_ALIGN_TRAP_EN, iAddr[1:0] SHALL be ignored and the access proceeds on the truncated word address.

Structure
REQ-028 The FSM state encoding and the WAIT-counter width constant (4 bits) SHALL live in the shared package data_mem_pkg.
REQ-029 The word array SHALL be a sub-module, data_mem_array: synchronous write, registered read, one port, DEPTH x 32.

Verification
REQ-030 WAIT=2: write 0xDEADBEEF to 0x10, then read 0x10 -> oAccessable high 3 cycles after each request, oRdData=0xDEADBEEF, oErr=0.
REQ-031 WAIT=0: back-to-back reads of 0x0 and 0x4 with the request held -> strobe every second cycle with correct data for each.
REQ-032 DEPTH=256: write 0x12345678 to 0x400 -> oErr=1 with the strobe; a read of 0x0 is unchanged; a read of 0x400 returns 0 with oErr=1.
REQ-033 iRst asserted in the 2nd WAIT cycle of a write of 0xA5A5A5A5 to 0x20 -> no strobe; a later read of 0x20 returns the old value.
REQ-034 iRd and iWr both high, iAddr=0x8, iWrData=0x1 -> write performed; a read of 0x8 returns 0x1.
REQ-035 Write to 0x22: macro defined -> oErr=1, nothing written; macro undefined -> oErr=0, word 0x20 written.
